// File: rtl/mult_arbiter_pkg.sv
// Shared widths and helpers for the multiplier arbiter.
package mult_arbiter_pkg;

    // Operand and product widths of the shared multiplier.
    localparam int OPW = 4;
    localparam int PW  = 8;

    // Ceiling log2, used to size requester ids.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Existing 4x4 unsigned combinational multiplier shared by all requesters.
module mult
    import mult_arbiter_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    // Zero-extend both operands so the product is computed at full width.
    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between NREQ requesters through
// a two-stage (operand / result) pipeline with full backpressure.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [OPW*NREQ-1:0]   req_a,
    input  logic [OPW*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [PW-1:0]         rsp_p,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [CNTW-1:0]       done_cnt
);

    // Pipeline and arbitration state.
    logic            s1_valid_q, s1_valid_d;
    logic [OPW-1:0]  s1_a_q, s1_a_d;
    logic [OPW-1:0]  s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]   rsp_p_q, rsp_p_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    // Combinational helpers.
    logic            s2_en_s;
    logic            s1_en_s;
    logic            found_s;
    logic            grant_any_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW:0]    cand_sum_s;
    logic [IDW-1:0]  cand_s;
    logic [IDW:0]    ptr_sum_s;
    logic [NREQ-1:0] grant_s;
    logic [PW-1:0]   mult_p_s;

    // A stage may advance when the stage downstream of it is free or draining.
    assign s2_en_s = !rsp_valid_q || rsp_ready;
    assign s1_en_s = !s1_valid_q || s2_en_s;

    // Round-robin search starting at ptr; the first valid requester wins.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        cand_sum_s  = '0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_sum_s >= (IDW+1)'(NREQ)) begin
                cand_sum_s = cand_sum_s - (IDW+1)'(NREQ);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_s = cand_sum_s[IDW-1:0];
            if (!found_s && req_valid[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Grant is only issued when stage 1 can accept an operand pair.
    assign grant_any_s = s1_en_s && found_s;
    assign grant_s     = grant_any_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s) : {NREQ{1'b0}};
    assign req_ready   = grant_s;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_sum_s = {1'b0, grant_idx_s} + {{IDW{1'b0}}, 1'b1};
        ptr_d     = ptr_q;
        if (grant_any_s) begin
            if (ptr_sum_s == (IDW+1)'(NREQ)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_sum_s[IDW-1:0];
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stage 1 next state: capture the granted operands or empty out.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        if (s1_en_s) begin
            s1_valid_d = grant_any_s;
            if (grant_any_s) begin
                s1_a_d  = req_a[grant_idx_s*OPW +: OPW];
                s1_b_d  = req_b[grant_idx_s*OPW +: OPW];
                s1_id_d = grant_idx_s;
            end else begin
                s1_id_d = s1_id_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    mult u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mult_p_s)
    );

    // Stage 2 next state: product and id are only replaced by a real operation.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        if (s2_en_s) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_p_d  = mult_p_s;
                rsp_id_d = s1_id_q;
            end else begin
                rsp_p_d  = rsp_p_q;
            end
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Completed-response counter, wraps naturally at its width.
    always_comb begin
        if (rsp_valid_q && rsp_ready) begin
            done_cnt_d = done_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            done_cnt_d = done_cnt_q;
        end
    end

    // State registers; reset discards every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            done_cnt_q  <= '0;
            ptr_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
            done_cnt_q  <= done_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign done_cnt  = done_cnt_q;
    assign busy      = s1_valid_q || rsp_valid_q;

endmodule
